// File: rtl/tmds_encoder_bank_if.sv
// Pixel-domain bundle for tmds_encoder_bank: per-lane data/control in,
// 10-bit TMDS symbols and aligned data-enable out.
interface tmds_encoder_bank_if #(
  parameter int NUM_CH = 3
);
  logic                 de;
  logic [NUM_CH*8-1:0]  data_in;
  logic [NUM_CH*2-1:0]  ctrl_in;
  logic [NUM_CH*10-1:0] tmds_out;
  logic                 de_out;

  modport master (output de, data_in, ctrl_in, input tmds_out, de_out);
  modport slave  (input de, data_in, ctrl_in, output tmds_out, de_out);
endinterface

// File: rtl/tmds_encoder_bank.sv
// NUM_CH-lane pipelined TMDS encoder with per-lane running disparity.
// Define TMDS_ENCODER_BANK_HDMI_GUARD_EN for HDMI preamble/guard insertion (NUM_CH must be 3).
module tmds_encoder_bank #(
  parameter int         NUM_CH   = 3,
  parameter logic [1:0] RST_CTRL = 2'b00
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  tmds_encoder_bank_if.slave bus
);
  typedef struct packed {
    logic [9:0]        sym;
    logic signed [4:0] cnt;
  } lane_out_t;

  localparam logic [9:0] GUARD_SYM_02 = 10'b1011001100;
  localparam logic [9:0] GUARD_SYM_1  = 10'b0100110011;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_code = 10'b1101010100;
      2'b01:   ctrl_code = 10'b0010101011;
      2'b10:   ctrl_code = 10'b0101010100;
      default: ctrl_code = 10'b1010101011;
    endcase
  endfunction

  localparam logic [9:0] RST_SYM = ctrl_code(RST_CTRL);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  // Updates are formed at 6 bits; the counter itself keeps 5.
  function automatic logic signed [4:0] wrap_cnt(input logic signed [5:0] v);
    return $signed(v[4:0]);
  endfunction

  function automatic lane_out_t dc_balance(input logic [8:0] qm, input logic [3:0] n1,
                                           input logic signed [4:0] cnt);
    lane_out_t         r;
    logic signed [5:0] cnt_w, bal, adj;
    cnt_w = {cnt[4], cnt};
    bal   = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    if (cnt == 5'sd0 || bal == 6'sd0) begin
      r.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      adj   = qm[8] ? bal : -bal;
    end else if ((cnt > 5'sd0 && bal > 6'sd0) || (cnt < 5'sd0 && bal < 6'sd0)) begin
      r.sym = {1'b1, qm[8], ~qm[7:0]};
      adj   = (qm[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      r.sym = {1'b0, qm[8], qm[7:0]};
      adj   = bal - (qm[8] ? 6'sd0 : 6'sd2);
    end
    r.cnt = wrap_cnt(cnt_w + adj);
    return r;
  endfunction

  logic                s0_de, s0_guard;
  logic [NUM_CH*8-1:0] s0_data;
  logic [NUM_CH*2-1:0] s0_ctrl;

  // ---- stage 0: optional lookahead delay line ----
`ifdef TMDS_ENCODER_BANK_HDMI_GUARD_EN
  localparam int DLY = 10;
  logic [DLY-1:0]               dly_de_d, dly_de_q;
  logic [DLY-1:0][NUM_CH*8-1:0] dly_data_d, dly_data_q;
  logic [DLY-1:0][NUM_CH*2-1:0] dly_ctrl_d, dly_ctrl_q;
  logic                         guard_ahead, preamble_ahead;

  always_comb begin
    dly_de_d   = {dly_de_q[DLY-2:0], bus.de};
    dly_data_d = {dly_data_q[DLY-2:0], bus.data_in};
    dly_ctrl_d = {dly_ctrl_q[DLY-2:0], bus.ctrl_in};
    // dly_de_d[9] is de one cycle after the stage-1 input, dly_de_d[0] ten cycles after
    guard_ahead    = !dly_de_q[DLY-1] && (|dly_de_d[DLY-1 -: 2]);
    preamble_ahead = !dly_de_q[DLY-1] && (|dly_de_d[DLY-3:0]) && !guard_ahead;
    s0_de    = dly_de_q[DLY-1];
    s0_data  = dly_data_q[DLY-1];
    s0_ctrl  = dly_ctrl_q[DLY-1];
    s0_guard = guard_ahead;
    if (preamble_ahead) begin
      s0_ctrl[3:2] = 2'b01;
      s0_ctrl[5:4] = 2'b00;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      dly_de_q   <= '0;
      dly_data_q <= '0;
      dly_ctrl_q <= {DLY{ {NUM_CH{RST_CTRL}} }};
    end else begin
      dly_de_q   <= dly_de_d;
      dly_data_q <= dly_data_d;
      dly_ctrl_q <= dly_ctrl_d;
    end
  end
`else
  always_comb begin
    s0_de    = bus.de;
    s0_data  = bus.data_in;
    s0_ctrl  = bus.ctrl_in;
    s0_guard = 1'b0;
  end
`endif

  // ---- stage 1: transition minimisation ----
  logic [NUM_CH-1:0][8:0] qm_p1_d, qm_p1_q;
  logic [NUM_CH-1:0][3:0] n1_p1_d, n1_p1_q;
  logic [NUM_CH*2-1:0]    ctrl_p1_d, ctrl_p1_q;
  logic                   vld_p1_d, vld_p1_q, guard_p1_d, guard_p1_q;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      qm_p1_d[k] = transition_min(s0_data[8*k +: 8]);
      n1_p1_d[k] = popcount8(qm_p1_d[k][7:0]);
    end
    ctrl_p1_d  = s0_ctrl;
    vld_p1_d   = s0_de;
    guard_p1_d = s0_guard;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      qm_p1_q    <= '0;
      n1_p1_q    <= '0;
      ctrl_p1_q  <= {NUM_CH{RST_CTRL}};
      vld_p1_q   <= 1'b0;
      guard_p1_q <= 1'b0;
    end else begin
      qm_p1_q    <= qm_p1_d;
      n1_p1_q    <= n1_p1_d;
      ctrl_p1_q  <= ctrl_p1_d;
      vld_p1_q   <= vld_p1_d;
      guard_p1_q <= guard_p1_d;
    end
  end

  // ---- stage 2: DC balancing and control/guard symbol selection ----
  lane_out_t              lane_bal [NUM_CH];
  logic signed [4:0]      cnt_d [NUM_CH];
  logic signed [4:0]      cnt_q [NUM_CH];
  logic [NUM_CH-1:0][9:0] sym_p2_d, sym_p2_q;
  logic                   vld_p2_d, vld_p2_q;

  always_comb begin
    vld_p2_d = vld_p1_q;
    for (int k = 0; k < NUM_CH; k++) begin
      lane_bal[k] = dc_balance(qm_p1_q[k], n1_p1_q[k], cnt_q[k]);
      if (!vld_p1_q) begin
        cnt_d[k] = '0;
        if (guard_p1_q) sym_p2_d[k] = (k == 1) ? GUARD_SYM_1 : GUARD_SYM_02;
        else            sym_p2_d[k] = ctrl_code(ctrl_p1_q[2*k +: 2]);
      end else begin
        cnt_d[k]    = lane_bal[k].cnt;
        sym_p2_d[k] = lane_bal[k].sym;
      end
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      sym_p2_q <= {NUM_CH{RST_SYM}};
      vld_p2_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
      sym_p2_q <= sym_p2_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  assign bus.tmds_out = sym_p2_q;
  assign bus.de_out   = vld_p2_q;
endmodule

// File: tb/tb_tmds_encoder_bank.sv
// Randomised bench for tmds_encoder_bank against a per-cycle reference encoder,
// plus literal symbol expectations for control codes, DC balance, latency and guard bands.
module tb_tmds_encoder_bank;
`ifdef TMDS_ENCODER_BANK_HDMI_GUARD_EN
  localparam int LAT   = 12;
  localparam bit GUARD = 1'b1;
`else
  localparam int LAT   = 2;
  localparam bit GUARD = 1'b0;
`endif
  localparam int NCH = 3;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;

  tmds_encoder_bank_if #(.NUM_CH(NCH)) bus ();

  tmds_encoder_bank #(.NUM_CH(NCH), .RST_CTRL(2'b00)) dut (
    .clk_pix(clk_pix),
    .rst_pix(rst_pix),
    .bus    (bus)
  );

  always #5 clk_pix = ~clk_pix;

  int n_checks = 0;
  int n_errors = 0;
  int i_idx    = 0;

  bit          h_de[$];
  logic [23:0] h_data[$];
  logic [5:0]  h_ctrl[$];
  logic [29:0] obs_sym[$];
  bit          obs_de[$];
  int          mcnt [NCH];
  int          disp [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit in_de(input int k);
    return (k < 0 || k >= h_de.size()) ? 1'b0 : h_de[k];
  endfunction

  function automatic logic [23:0] in_data(input int k);
    return (k < 0 || k >= h_data.size()) ? 24'h0 : h_data[k];
  endfunction

  function automatic logic [5:0] in_ctrl(input int k);
    return (k < 0 || k >= h_ctrl.size()) ? 6'h0 : h_ctrl[k];
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Reference: q_m bit i is the parity of d[0..i], inverted on odd bits for the XNOR chain.
  function automatic logic [9:0] ref_lane(input logic [7:0] d, inout int cnt);
    int         n1d, ones, bal;
    bit         xn, q8;
    logic [7:0] qm;
    logic [9:0] sym;
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q8  = !xn;
    for (int i = 0; i < 8; i++)
      qm[i] = ((($countones(int'(d) & ((1 << (i + 1)) - 1)) % 2) != 0)) ^ (xn && (i % 2 == 1));
    ones = $countones(qm);
    bal  = 2 * ones - 8;
    if (cnt == 0 || bal == 0) begin
      sym = q8 ? {2'b01, qm} : {2'b10, ~qm};
      cnt = cnt + (q8 ? bal : -bal);
    end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
      sym = {1'b1, q8, ~qm};
      cnt = cnt + 2 * int'(q8) - bal;
    end else begin
      sym = {1'b0, q8, qm};
      cnt = cnt + bal - 2 * int'(!q8);
    end
    return sym;
  endfunction

  task automatic check_output(input int k);
    bit          de_k, guard, pre, bounded;
    logic [23:0] data_k;
    logic [5:0]  ctrl_k;
    logic [1:0]  c;
    logic [29:0] exp_sym;
    de_k   = in_de(k);
    data_k = in_data(k);
    ctrl_k = in_ctrl(k);
    guard  = 1'b0;
    pre    = 1'b0;
    if (GUARD && !de_k) begin
      guard = in_de(k + 1) || in_de(k + 2);
      for (int j = 3; j <= 10; j++) if (in_de(k + j)) pre = 1'b1;
    end
    for (int l = 0; l < NCH; l++) begin
      if (de_k) begin
        exp_sym[10*l +: 10] = ref_lane(data_k[8*l +: 8], mcnt[l]);
      end else begin
        mcnt[l] = 0;
        if (guard) begin
          exp_sym[10*l +: 10] = (l == 1) ? 10'h133 : 10'h2CC;
        end else begin
          c = ctrl_k[2*l +: 2];
          if (pre && l == 1) c = 2'b01;
          if (pre && l == 2) c = 2'b00;
          exp_sym[10*l +: 10] = ctrl_sym(c);
        end
      end
    end
    check($sformatf("tmds_out k=%0d", k), 32'(bus.tmds_out), 32'(exp_sym));
    check($sformatf("de_out k=%0d", k), 32'(bus.de_out), 32'(de_k));
    for (int l = 0; l < NCH; l++) begin
      if (bus.de_out === 1'b1) begin
        disp[l] = disp[l] + 2 * $countones(bus.tmds_out[10*l +: 10]) - 10;
        bounded = (disp[l] >= -8) && (disp[l] <= 8);
        check($sformatf("disparity_bound lane=%0d k=%0d", l, k), 32'(bounded), 32'd1);
      end else begin
        disp[l] = 0;
      end
    end
    if (k >= 0) begin
      obs_sym.push_back(bus.tmds_out);
      obs_de.push_back(bus.de_out);
    end
  endtask

  task automatic step(input bit de, input logic [23:0] data, input logic [5:0] ctrl);
    if (i_idx > 0) begin
      @(negedge clk_pix);
      check_output(i_idx - LAT);
    end
    bus.de      = de;
    bus.data_in = data;
    bus.ctrl_in = ctrl;
    h_de.push_back(de);
    h_data.push_back(data);
    h_ctrl.push_back(ctrl);
    i_idx++;
  endtask

  task automatic blank(input int n, input logic [5:0] ctrl);
    repeat (n) step(1'b0, 24'($urandom), ctrl);
  endtask

  task automatic release_reset();
    @(negedge clk_pix);
    h_de.delete();
    h_data.delete();
    h_ctrl.delete();
    obs_sym.delete();
    obs_de.delete();
    for (int l = 0; l < NCH; l++) begin
      mcnt[l] = 0;
      disp[l] = 0;
    end
    i_idx   = 0;
    rst_pix = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    for (int l = 0; l < NCH; l++)
      check($sformatf("%s tmds lane=%0d", name, l), 32'(bus.tmds_out[10*l +: 10]), 32'h354);
    check($sformatf("%s de_out", name), 32'(bus.de_out), 32'd0);
  endtask

  task automatic lit(input string name, input int k, input int lane, input logic [9:0] req);
    logic [9:0] act;
    if (k < 0 || k >= obs_sym.size()) act = 'x;
    else                              act = obs_sym[k][10*lane +: 10];
    check($sformatf("%s k=%0d lane=%0d", name, k, lane), 32'(act), 32'(req));
  endtask

  task automatic lit_de(input string name, input int k, input bit req);
    logic act;
    if (k < 0 || k >= obs_de.size()) act = 'x;
    else                             act = obs_de[k];
    check($sformatf("%s k=%0d", name, k), 32'(act), 32'(req));
  endtask

  task automatic mid_reset();
    #2;
    rst_pix = 1'b1;
    #1;
    check_reset_state("async_reset");
    repeat (2) @(negedge clk_pix);
    check_reset_state("held_reset");
    release_reset();
  endtask

  initial begin
    int k0, pix, run;
    bit did_reset;
    bus.de      = 1'b0;
    bus.data_in = '0;
    bus.ctrl_in = '0;
    repeat (2) @(negedge clk_pix);
    check_reset_state("power_on_reset");
    release_reset();

    // Control code sequence on lane 0
    k0 = i_idx;
    step(1'b0, 24'h0, 6'b000000);
    step(1'b0, 24'h0, 6'b000001);
    step(1'b0, 24'h0, 6'b000010);
    step(1'b0, 24'h0, 6'b000011);
    blank(LAT + 4, 6'b000000);
    lit("ctrl_00", k0,     0, 10'h354);
    lit("ctrl_01", k0 + 1, 0, 10'h0AB);
    lit("ctrl_10", k0 + 2, 0, 10'h154);
    lit("ctrl_11", k0 + 3, 0, 10'h2AB);

    // DC balance on all-zero pixels
    blank(12, 6'b000000);
    k0 = i_idx;
    repeat (4) step(1'b1, 24'h000000, 6'b000000);
    blank(LAT + 14, 6'b000000);
    lit("dc_zero_0", k0,     0, 10'h100);
    lit("dc_zero_1", k0 + 1, 0, 10'h3FF);
    lit("dc_zero_2", k0 + 2, 0, 10'h100);
    lit("dc_zero_3", k0 + 3, 2, 10'h3FF);

    // Single-cycle de pulse
    k0 = i_idx;
    step(1'b1, {3{8'hA5}}, 6'b000000);
    blank(LAT + 14, 6'b000000);
    lit_de("pulse_de_before", k0 - 1, 1'b0);
    lit_de("pulse_de", k0, 1'b1);
    lit_de("pulse_de_after", k0 + 1, 1'b0);
    lit("pulse_sym_a5", k0, 1, 10'h163);

`ifdef TMDS_ENCODER_BANK_HDMI_GUARD_EN
    // 20-cycle blanking: full preamble and guard band
    repeat (3) step(1'b1, 24'($urandom), 6'b000000);
    blank(20, 6'b111111);
    k0 = i_idx;
    repeat (4) step(1'b1, 24'($urandom), 6'b000000);
    blank(LAT + 14, 6'b000000);
    lit("unforced_lane1", k0 - 11, 1, 10'h2AB);
    for (int j = 10; j >= 3; j--) begin
      lit("preamble_lane0", k0 - j, 0, 10'h2AB);
      lit("preamble_lane1", k0 - j, 1, 10'h0AB);
      lit("preamble_lane2", k0 - j, 2, 10'h354);
    end
    for (int j = 2; j >= 1; j--) begin
      lit("guard_lane0", k0 - j, 0, 10'h2CC);
      lit("guard_lane1", k0 - j, 1, 10'h133);
      lit("guard_lane2", k0 - j, 2, 10'h2CC);
      lit_de("guard_de", k0 - j, 1'b0);
    end
    // 5-cycle blanking: truncated preamble
    repeat (3) step(1'b1, 24'($urandom), 6'b000000);
    blank(5, 6'b111111);
    k0 = i_idx;
    repeat (4) step(1'b1, 24'($urandom), 6'b000000);
    blank(LAT + 14, 6'b000000);
    for (int j = 5; j >= 3; j--) begin
      lit("short_preamble_lane1", k0 - j, 1, 10'h0AB);
      lit("short_preamble_lane2", k0 - j, 2, 10'h354);
    end
    for (int j = 2; j >= 1; j--) begin
      lit("short_guard_lane0", k0 - j, 0, 10'h2CC);
      lit("short_guard_lane1", k0 - j, 1, 10'h133);
    end
`endif

    // Random pixels with periodic blanking and a mid-frame reset
    pix       = 0;
    did_reset = 1'b0;
    while (pix < 10000) begin
      run = $urandom_range(1, 40);
      for (int j = 0; j < run; j++) begin
        step(1'b1, 24'($urandom), 6'($urandom));
        pix++;
        if (!did_reset && pix >= 5000 && j == 2) begin
          mid_reset();
          did_reset = 1'b1;
        end
      end
      blank($urandom_range(1, 16), 6'($urandom));
    end
    blank(LAT + 4, 6'b000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    n_errors++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/tmds_encoder_bank.md
Name: tmds_encoder_bank

Overview:
- Parametrised, pipelined TMDS encoder bank in the pixel clock domain.
- Converts NUM_CH lanes of 8-bit pixel data plus 2-bit control into 10-bit DVI symbols, with per-lane running-disparity DC balancing.
- Output words feed the serialiser stage downstream.
- Successor to the fixed three-channel encode path: channel count is generic, the pipeline is registered, and HDMI video preamble/guard-band insertion is optional.

Parameters:
- NUM_CH, 3, number of TMDS data lanes (1..8; must be 3 when HDMI_GUARD_EN is defined).
- RST_CTRL, 2'b00, control value whose code is driven on every lane during and after reset.

Ports:
- clk_pix  in  1  pixel clock; all logic on rising edge.
- rst_pix  in  1  asynchronous, active-high reset.
- de  in  1  data enable; high = active video.
- data_in  in  NUM_CH*8  lane k data at [8k+7:8k].
- ctrl_in  in  NUM_CH*2  lane k control at [2k+1:2k]; lane 0 = {vsync,hsync}.
- tmds_out  out  NUM_CH*10  lane k symbol at [10k+9:10k]; bit 0 is transmitted first.
- de_out  out  1  de aligned with tmds_out.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock release):
  - All pipeline registers clear.
  - Every lane of tmds_out holds the control code for RST_CTRL.
  - de_out = 0; all disparity counters = 0.
- Latency: exactly LAT cycles from input to tmds_out/de_out; LAT = 2 without the feature, 12 with it. No backpressure; one symbol per lane every cycle.
- Stage 1 (per lane, registered):
  - N1 = popcount(data).
  - If N1 > 4, or (N1 == 4 and data[0] == 0): XNOR chain, q_m[8] = 0. Otherwise XOR chain, q_m[8] = 1.
  - Chain: q_m[0] = d[0]; q_m[i] = q_m[i-1] op d[i].
  - Register q_m[8:0], the popcount of q_m[7:0], de and ctrl.
- Stage 2 (per lane, registered). cnt is a signed 5-bit register per lane; n1/n0 are the q_m[7:0] ones/zeros counts.
  - de = 0: emit control code; cnt <= 0. Codes: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
  - de = 1, cnt == 0 or n1 == n0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. If q_m[8] then cnt += n1-n0, else cnt += n0-n1.
  - de = 1, (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1): out = {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + n0 - n1.
  - de = 1, otherwise: out = {0, q_m[8], q_m[7:0]}; cnt += n1 - n0 - 2*(~q_m[8]).
- Arithmetic: all cnt updates are done at 6-bit signed width and truncated to 5 bits. |cnt| never exceeds 8 for legal inputs.
- Simultaneous events: de toggling every cycle is legal; each cycle is encoded independently apart from cnt.
- A de 1->0 edge resets cnt on the first blanking cycle at stage 2.
- Reset mid-frame discards in-flight symbols. The first valid symbol appears LAT cycles after the first clock following release.

Optional Feature:
- Macro: TMDS_ENCODER_BANK_HDMI_GUARD_EN.
- Defined:
  - A 10-deep delay line on de/data/ctrl provides lookahead, so LAT = 12.
  - Let the delayed de (before stage 1) rise at cycle T.
  - Cycles T-10..T-3 with delayed de = 0 are the preamble. Lane 1 ctrl is forced to 2'b01 and lane 2 ctrl to 2'b00; lane 0 keeps hsync/vsync.
  - Cycles T-2..T-1 with delayed de = 0 are the guard band. Lane 0 and lane 2 output 10'b1011001100; lane 1 outputs 10'b0100110011.
  - Guard band overrides preamble. Neither is ever applied to a cycle whose delayed de = 1, so blanking shorter than 10 cycles gets a truncated preamble and/or guard.
  - de_out stays low during guard cycles.
- Undefined: no delay line, LAT = 2, no forced codes; pure DVI.

Test Plan:
- Reset: hold rst_pix for 3 cycles mid-stream -> tmds_out lanes = 10'b1101010100 and de_out = 0 immediately (asynchronous); cnt = 0.
- Control codes: de = 0, step ctrl_in lane 0 through 00, 01, 10, 11 -> after LAT cycles lane 0 shows 0x354, 0x0AB, 0x154, 0x2AB in order.
- DC balance: de = 1, data = 0x00 on all lanes for 4 cycles -> symbols 0x100, 0x3FF, 0x100, ... with cnt sequence -8, +2, -6.
- Random data: 10k random pixels with periodic blanking -> a bit-exact reference encoder matches; cnt stays within [-8, 8]; total ones minus zeros stays bounded.
- Latency/alignment: single de pulse of 1 cycle with data 0xA5 -> de_out high for exactly one cycle, LAT cycles later, carrying the encoded 0xA5.
- With TMDS_ENCODER_BANK_HDMI_GUARD_EN: 20-cycle blanking then de rise -> output cycles 10..3 before de_out rises show lane 1 code 0x0AB and lane 2 code 0x354; the 2 cycles before show 0x2CC/0x133/0x2CC. With 5-cycle blanking -> 3 preamble-forced cycles then 2 guard cycles.
